prog_freq_divider: RTL

//  Runtime-programmable integer clock divider. Generalises the fixed lab divider to a WIDTH-bit divisor N,

---
 rtl/freq_div_pkg.sv | 27 ++
 rtl/div_mod_counter.sv | 32 +++
 rtl/prog_freq_divider.sv | 127 ++++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable frequency divider.
// Provides duty-mode encodings and the high-phase length function.
package freq_div_pkg;

    // Duty mode encodings
    localparam logic DUTY_HALF  = 1'b0;
    localparam logic DUTY_PULSE = 1'b1;

    // Working width of the helper function; callers cast to their WIDTH.
    localparam int FN_W = 32;

    // Number of cycles clk_out stays high in a period of n cycles.
    // Half mode rounds up, so odd n gives the extra cycle to the high phase.
    function automatic logic [FN_W-1:0] high_len(
        input logic [FN_W-1:0] n,
        input logic            duty
    );
        logic [FN_W-1:0] h;
        if (duty == DUTY_PULSE) begin
            h = FN_W'(1);
        end else begin
            h = (n >> 1) + {{(FN_W-1){1'b0}}, n[0]};
        end
        return h;
    endfunction

endpackage

// File: rtl/div_mod_counter.sv
// Modulo-N up counter with synchronous clear, count enable and terminal flag.
// Ports: clk, init (sync reset), clr, en, modulus -> cnt, last (cnt == modulus-1).
module div_mod_counter
    import freq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             init,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    // Only meaningful while modulus != 0; the owner keeps en low otherwise.
    assign last = (cnt == (modulus - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (init || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable integer clock divider producing a clock-enable waveform
// and a period-start tick. Divisor/duty updates are shadowed and applied only
// at period boundaries, so a running waveform never glitches.
// Ports: clk, init (sync reset), en, div_load, div_val, duty_sel
//        -> clk_out, tick, div_active, pending.
module prog_freq_divider
    import freq_div_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter int   DEFAULT_DIV  = 3,
    parameter logic DEFAULT_DUTY = 1'b0
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    input  logic             duty_sel,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             pending
);

    logic [WIDTH-1:0] act_div;
    logic             act_duty;
    logic [WIDTH-1:0] sh_div;
    logic             sh_duty;
    logic             idle;

    logic [WIDTH-1:0] cnt;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_en;

    logic             boundary;
    logic [WIDTH-1:0] nxt_div;
    logic             nxt_duty;
    logic [WIDTH-1:0] hi_len;
    logic [WIDTH-1:0] cnt_nx;

    // Leaving idle and wrapping the counter are both period starts.
    assign boundary = en && (idle || cnt_last);

    // Configuration for the period that starts on a boundary edge.
    // A load on that same edge takes priority over the shadow.
    always_comb begin
        nxt_div  = act_div;
        nxt_duty = act_duty;
        if (div_load) begin
            nxt_div  = div_val;
            nxt_duty = duty_sel;
        end else if (pending) begin
            nxt_div  = sh_div;
            nxt_duty = sh_duty;
        end
    end

    assign hi_len = WIDTH'(high_len(FN_W'(act_div), act_duty));

    // Only used on running edges where cnt < N-1, so it cannot overflow.
    assign cnt_nx = cnt + WIDTH'(1);

    // Counter is held at zero whenever idle or disabled; starting a period
    // from idle therefore begins at cnt = 0 without a separate load path.
    assign cnt_clr = !en || idle;
    assign cnt_en  = en && !idle;

    div_mod_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .init    (init),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .modulus (act_div),
        .cnt     (cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (init) begin
            act_div  <= WIDTH'(DEFAULT_DIV);
            act_duty <= DEFAULT_DUTY;
            sh_div   <= WIDTH'(DEFAULT_DIV);
            sh_duty  <= DEFAULT_DUTY;
            pending  <= 1'b0;
            idle     <= 1'b1;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (boundary) begin
            act_div  <= nxt_div;
            act_duty <= nxt_duty;
            pending  <= 1'b0;
            if (div_load) begin
                sh_div  <= div_val;
                sh_duty <= duty_sel;
            end
            if (nxt_div == '0) begin
                idle    <= 1'b1;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                idle    <= 1'b0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
            end
        end else begin
            if (div_load) begin
                sh_div  <= div_val;
                sh_duty <= duty_sel;
                pending <= 1'b1;
            end
            if (!en) begin
                idle    <= 1'b1;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                tick    <= 1'b0;
                clk_out <= (cnt_nx < hi_len);
            end
        end
    end

    assign div_active = act_div;

endmodule
